// File: rtl/pipe_redirect_ctrl.sv
// Hazard, redirect and interrupt-entry control for the 5-stage pipeline.
// Drives PC enable, forced vector select, IF/ID and ID/EX stall/flush and EPC writes.
module pipe_redirect_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        if_pc_k,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_undef,
    input  logic [2:0]  id_pcsrc,
    input  logic [2:0]  ex_pcsrc,
    input  logic        ex_branch_taken,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    output logic        if_upd_pc,
    output logic [2:0]  vec_sel,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        epc_we,
    output logic [31:0] epc_data,
    output logic        irq_ack
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [2:0] PC_BRANCH = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_JR     = 3'd3;
    localparam logic [2:0] VEC_NONE  = 3'd0;
    localparam logic [2:0] VEC_IRQ   = 3'd4;
    localparam logic [2:0] VEC_EXC   = 3'd5;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        TAKE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [NS-1:0] sync;
    logic          irq_s;
    logic          ex_redirect;
    logic          rs_hit;
    logic          rt_hit;
    logic          lu;
    logic          exc;
    logic          take;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[NS-2:0], irq};
        end
    end

    assign irq_s = sync[NS-1];

    assign ex_redirect = ((ex_pcsrc == PC_BRANCH) && ex_branch_taken)
                       || (ex_pcsrc == PC_JR);

    assign rs_hit = (ex_rt == id_rs);
    assign rt_hit = id_uses_rt && (ex_rt == id_rt);

    assign lu = ex_memread && (ex_rt != 5'd0)
              && (rs_hit || rt_hit) && !ex_redirect;

    assign exc = id_valid && id_undef && !ex_redirect;

    // A registered TAKE yields to any redirect or exception in its cycle.
    assign take = (state == TAKE) && !ex_redirect && !exc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (irq_s && !if_pc_k) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!irq_s || if_pc_k) begin
                    state_nxt = RUN;
                end else if (id_valid && !ex_redirect && !lu && !exc) begin
                    state_nxt = TAKE;
                end
            end
            TAKE: begin
                state_nxt = take ? RUN : WAIT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        if_upd_pc  = 1'b1;
        vec_sel    = VEC_NONE;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        epc_we     = 1'b0;
        epc_data   = 32'd0;
        irq_ack    = 1'b0;
        // Held at reset values while reset is asserted, whatever the inputs.
        if (reset) begin
            if (ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (exc) begin
                vec_sel    = VEC_EXC;
                epc_we     = 1'b1;
                epc_data   = id_pc;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (take) begin
                vec_sel    = VEC_IRQ;
                epc_we     = 1'b1;
                epc_data   = id_pc;
                irq_ack    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu) begin
                if_upd_pc  = 1'b0;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end else if (id_pcsrc == PC_JUMP) begin
                ifid_flush = 1'b1;
            end
        end
    end

endmodule

// File: doc/pipe_redirect_ctrl.md
# pipe_redirect_ctrl

Pipeline hazard and redirect controller for the 5-stage CPU. It generates the program-counter update enable, the forced PC-source selection for interrupt and exception vectors, and the IF/ID and ID/EX stall and flush controls. It sits beside the PC register and the IF/ID and ID/EX pipeline registers. It sequences interrupt entry so that an interrupt is never taken while a branch or jump-register redirect is unresolved.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: flops in the `irq` synchronizer, minimum 2.

Ports:
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `irq` input 1: external interrupt request, level, asynchronous to `clk`.
- `if_pc_k` input 1: bit 31 of the IF-stage PC; 1 = kernel mode.
- `id_valid` input 1: the ID stage holds a real instruction, not a bubble.
- `id_pc` input 32: PC of the ID-stage instruction.
- `id_rs`, `id_rt` input 5: source register numbers in ID.
- `id_uses_rt` input 1: the ID instruction reads `rt`.
- `id_undef` input 1: the ID instruction is undefined (exception).
- `id_pcsrc` input 3: PC source decoded in ID. 2 = jump.
- `ex_pcsrc` input 3: PC source in EX. 1 = branch, 3 = jump-register.
- `ex_branch_taken` input 1: branch condition result in EX.
- `ex_memread` input 1: the EX instruction is a load.
- `ex_rt` input 5: load destination register.
- `if_upd_pc` output 1: PC advances this cycle.
- `vec_sel` output 3: forced PC source. 0 = none, 4 = interrupt vector 0x80000004, 5 = exception vector 0x80000008.
- `ifid_stall` output 1: hold the IF/ID register.
- `ifid_flush` output 1: load a bubble into IF/ID.
- `idex_flush` output 1: load a bubble into ID/EX.
- `epc_we` output 1: write EPC this cycle.
- `epc_data` output 32: value to write into EPC.
- `irq_ack` output 1: one-cycle pulse when interrupt entry is performed.

## Operation

- **EX redirect.** `ex_redirect = (ex_pcsrc==1 && ex_branch_taken) || ex_pcsrc==3`. When it is true:
  - `ifid_flush=1` and `idex_flush=1`.
  - A load-use stall is not asserted.
  - An exception or interrupt is not taken.
- **Load-use hazard.** `lu = ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)) && !ex_redirect`. When it is true: `if_upd_pc=0`, `ifid_stall=1`, `idex_flush=1`.
- **ID jump.** When `id_pcsrc==2 && !ex_redirect && !lu`: `ifid_flush=1`.
- **Exception.** `exc = id_valid && id_undef && !ex_redirect`. It takes priority over load-use and interrupt, and is taken in either mode. When it is true:
  - `vec_sel=5`, `epc_we=1`, `epc_data=id_pc`.
  - `ifid_flush=1`, `idex_flush=1`, `if_upd_pc=1`.
- **Interrupt FSM.** `irq_s` is the output of the synchronizer.
  - **RUN:** if `irq_s && !if_pc_k`, go to WAIT.
  - **WAIT:** each cycle, if `!irq_s || if_pc_k`, return to RUN and drop the request. Otherwise, if `id_valid && !ex_redirect && !lu && !exc`, go to TAKE. Otherwise stay in WAIT.
  - **TAKE (1 cycle):**
    - `vec_sel=4`, `epc_we=1`, `epc_data=id_pc`, `irq_ack=1`.
    - `ifid_flush=1`, `idex_flush=1`, `if_upd_pc=1`.
    - Next state is RUN.
  - The TAKE decision is registered, so entry happens the cycle after the WAIT condition holds. If an exception or EX redirect appears in the TAKE cycle, TAKE is abandoned without effect and the FSM returns to WAIT. The exception or redirect proceeds normally.
- **Priority:** `ex_redirect` > `exc` > TAKE > `lu` > ID jump > sequential.
- **Defaults:** `if_upd_pc=1` and all other outputs 0.

## Timing

- **Reset values** (asserted asynchronously):
  - FSM in RUN; synchronizer flops 0.
  - `vec_sel=0`, `epc_we=0`, `epc_data=0`, `irq_ack=0`.
  - All stall and flush outputs 0; `if_upd_pc=1`.
- **Combinational outputs:** hazard, redirect and exception outputs are combinational from inputs in the same cycle.
- **Interrupt latency:** minimum from `irq` rising to `irq_ack` is `SYNC_STAGES`+2 cycles (sync, RUN→WAIT, WAIT→TAKE).
- **Long load-use sequences:** back-to-back load-use stalls hold the FSM in WAIT indefinitely.
- **Reset mid-WAIT or mid-TAKE:** returns to RUN with no `epc_we`.

## Test plan

1. Load to r5, then `add` reading r5: exactly one cycle of `if_upd_pc=0`, `ifid_stall=1`, `idex_flush=1`; load to r0 causes no stall.
2. `ex_pcsrc=1`, `ex_branch_taken=1`, with a simultaneous load-use match: `ifid_flush=1` and `idex_flush=1`, `ifid_stall=0`, `if_upd_pc=1`. With `ex_branch_taken=0`: no flush.
3. `id_undef=1`, `id_valid=1`, `id_pc=0x00400010`: same cycle `vec_sel=5`, `epc_we=1`, `epc_data=0x00400010`. Repeat with `ex_pcsrc=3`: no exception.
4. `irq` raised in user mode, `id_pc=0x00400020`, no hazards: `irq_ack` at cycle 4 with `epc_data=0x00400020`, `vec_sel=4`, then RUN.
5. `irq` raised while `ex_pcsrc=1` taken and `id_valid=0` for 2 cycles: FSM stays in WAIT, entry occurs after both clear. `irq` raised with `if_pc_k=1`: no `irq_ack`.
6. Drop `reset` during WAIT: all outputs return to reset values immediately; no EPC write after release until `irq` is re-synchronized.
